// File: rtl/op_dispatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// op_dispatch_ctrl_if
//
// Bundles the request, execution-unit and result signals of op_dispatch_ctrl.
//
//   Request channel  : req_valid, req_ready, req_unit, req_op, req_size,
//                      req_reg, req_opa, req_opb
//   Unit bus         : unit_op, unit_opa, unit_opb, fpu_start, fpu_ready,
//                      fpu_result, bm_result, calc_result, log_result
//   Result channel   : res_valid, res_data, res_sign, res_err, res_ack
//
// Modports:
//   slave  - the dispatch controller itself
//   master - the surrounding system (operator-input FSM plus the units)
// ---------------------------------------------------------------------------
interface op_dispatch_ctrl_if;

    // Request channel
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_unit;
    logic [2:0]  req_op;
    logic [1:0]  req_size;
    logic [1:0]  req_reg;
    logic [63:0] req_opa;
    logic [63:0] req_opb;

    // Shared execution datapath
    logic [2:0]  unit_op;
    logic [63:0] unit_opa;
    logic [63:0] unit_opb;
    logic        fpu_start;
    logic        fpu_ready;
    logic [63:0] fpu_result;
    logic [63:0] bm_result;
    logic [63:0] calc_result;
    logic [63:0] log_result;

    // Result channel
    logic        res_valid;
    logic [63:0] res_data;
    logic        res_sign;
    logic        res_err;
    logic        res_ack;

    modport slave (
        input  req_valid, req_unit, req_op, req_size, req_reg, req_opa, req_opb,
        input  fpu_ready, fpu_result, bm_result, calc_result, log_result,
        input  res_ack,
        output req_ready,
        output unit_op, unit_opa, unit_opb, fpu_start,
        output res_valid, res_data, res_sign, res_err
    );

    modport master (
        output req_valid, req_unit, req_op, req_size, req_reg, req_opa, req_opb,
        output fpu_ready, fpu_result, bm_result, calc_result, log_result,
        output res_ack,
        input  req_ready,
        input  unit_op, unit_opa, unit_opb, fpu_start,
        input  res_valid, res_data, res_sign, res_err
    );

endinterface

// File: rtl/op_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// op_dispatch_ctrl
//
// Sequencer between the operator-input FSM and the shared execution datapath
// (FPU, bit-manip, integer-calc, integer-logic) plus a 4x64 stored-value
// register file. One request is accepted at a time, issued with size-masked
// operands, completed after a fixed latency (integer units) or on fpu_ready
// (with timeout), and the masked, sign-flagged result is held until acked.
//
// Parameters:
//   INT_LAT     - cycles from issue to valid result for units 001..011 (1..15)
//   FPU_TIMEOUT - max WAIT cycles for fpu_ready before abort (1..255)
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset (aborts any operation)
//   bus  - op_dispatch_ctrl_if.slave: request, unit and result channels
//
// Unit codes: 000 fpu, 001 bit-manip, 010 int-calc, 011 int-logic,
//             100 fetch, 101 store, 11x illegal.
// Size codes: 00 16-bit, 01 32-bit, 1x 64-bit.
// ---------------------------------------------------------------------------
module op_dispatch_ctrl #(
    parameter int unsigned INT_LAT     = 1,
    parameter int unsigned FPU_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    op_dispatch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [2:0] U_FPU   = 3'b000;
    localparam logic [2:0] U_BM    = 3'b001;
    localparam logic [2:0] U_CALC  = 3'b010;
    localparam logic [2:0] U_LOG   = 3'b011;
    localparam logic [2:0] U_FETCH = 3'b100;
    localparam logic [2:0] U_STORE = 3'b101;

    // Last WAIT count value before completion / abort.
    localparam logic [7:0] INT_LAST = 8'(INT_LAT - 1);
    localparam logic [7:0] FPU_LAST = 8'(FPU_TIMEOUT - 1);

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [63:0] size_mask(input logic [63:0] v,
                                              input logic [1:0]  size);
        case (size)
            2'b00:   return {48'd0, v[15:0]};
            2'b01:   return {32'd0, v[31:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic size_msb(input logic [63:0] v,
                                      input logic [1:0]  size);
        case (size)
            2'b00:   return v[15];
            2'b01:   return v[31];
            default: return v[63];
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state;
    logic [2:0]  unit_q;
    logic [1:0]  size_q;
    logic [1:0]  reg_q;
    logic [2:0]  op_q;
    logic [63:0] opa_q;          // already masked to size_q
    logic [63:0] opb_q;          // already masked to size_q
    logic [7:0]  wait_cnt;
    logic [63:0] regs [4];

    logic        req_ready_q;
    logic        fpu_start_q;
    logic        res_valid_q;
    logic [63:0] res_data_q;
    logic        res_sign_q;
    logic        res_err_q;

    // -----------------------------------------------------------------------
    // Completion decode: says whether this cycle ends the operation and with
    // what raw result. Only ISSUE and WAIT can complete; fpu_ready is looked
    // at in WAIT only, so stray pulses elsewhere have no effect.
    // -----------------------------------------------------------------------
    logic        done;
    logic        done_err;
    logic [63:0] done_raw;
    logic [63:0] done_data;
    logic [63:0] int_result;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        int_result = '0;
        case (unit_q)
            U_BM:    int_result = bus.bm_result;
            U_CALC:  int_result = bus.calc_result;
            U_LOG:   int_result = bus.log_result;
            default: int_result = '0;
        endcase
    end

    always_comb begin
        done     = 1'b0;
        done_err = 1'b0;
        done_raw = '0;
        case (state)
            S_ISSUE: begin
                case (unit_q)
                    U_FPU, U_BM, U_CALC, U_LOG: done = 1'b0;
                    U_FETCH: begin
                        done     = 1'b1;
                        done_raw = regs[reg_q];
                    end
                    U_STORE: begin
                        done     = 1'b1;
                        done_raw = opa_q;
                    end
                    default: begin
                        done     = 1'b1;
                        done_err = 1'b1;
                    end
                endcase
            end
            S_WAIT: begin
                if (unit_q == U_FPU) begin
                    // Ready wins over a coinciding timeout.
                    if (bus.fpu_ready) begin
                        done     = 1'b1;
                        done_raw = bus.fpu_result;
                    end else if (wait_cnt == FPU_LAST) begin
                        done     = 1'b1;
                        done_err = 1'b1;
                    end
                end else if (wait_cnt == INT_LAST) begin
                    done     = 1'b1;
                    done_raw = int_result;
                end
            end
            default: done = 1'b0;
        endcase
    end

    // Every result, FPU included, is trimmed to the latched size.
    assign done_data = size_mask(done_raw, size_q);

    // -----------------------------------------------------------------------
    // Sequencer with registered outputs
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            unit_q      <= '0;
            size_q      <= '0;
            reg_q       <= '0;
            op_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            wait_cnt    <= '0;
            req_ready_q <= 1'b1;
            fpu_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sign_q  <= 1'b0;
            res_err_q   <= 1'b0;
            // NOTE: the register file is architecturally visible and must
            // read back zero after reset, so it is reset like any other
            // state; four entries keep this cheap.
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            fpu_start_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        unit_q      <= bus.req_unit;
                        size_q      <= bus.req_size;
                        reg_q       <= bus.req_reg;
                        op_q        <= bus.req_op;
                        opa_q       <= size_mask(bus.req_opa, bus.req_size);
                        opb_q       <= size_mask(bus.req_opb, bus.req_size);
                        req_ready_q <= 1'b0;
                        // Launch pulse lands in the ISSUE cycle only.
                        fpu_start_q <= (bus.req_unit == U_FPU);
                        state       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    wait_cnt <= '0;
                    if (unit_q == U_STORE) begin
                        regs[reg_q] <= opa_q;
                    end
                    state <= done ? S_HOLD : S_WAIT;
                end

                S_WAIT: begin
                    if (done) begin
                        state <= S_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_HOLD: begin
                    if (bus.res_ack) begin
                        // res_data deliberately keeps its last value.
                        state       <= S_IDLE;
                        res_valid_q <= 1'b0;
                        res_sign_q  <= 1'b0;
                        res_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase

            // Result capture shared by every completing path.
            if (done) begin
                res_valid_q <= 1'b1;
                res_data_q  <= done_data;
                res_sign_q  <= size_msb(done_data, size_q);
                res_err_q   <= done_err;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.req_ready = req_ready_q;
    assign bus.unit_op   = op_q;
    assign bus.unit_opa  = opa_q;
    assign bus.unit_opb  = opb_q;
    assign bus.fpu_start = fpu_start_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_sign  = res_sign_q;
    assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_op_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_op_dispatch_ctrl
//
// Directed bench for op_dispatch_ctrl built with INT_LAT=1, FPU_TIMEOUT=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// "Edge 1" below is the edge at which the request is accepted.
// ---------------------------------------------------------------------------
module tb_op_dispatch_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    op_dispatch_ctrl_if bus_if ();

    op_dispatch_ctrl #(
        .INT_LAT     (1),
        .FPU_TIMEOUT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present a request for exactly one edge (the accepting edge).
    task automatic issue(input logic [2:0] unit, input logic [2:0] op,
                         input logic [1:0] size, input logic [1:0] idx,
                         input logic [63:0] opa, input logic [63:0] opb);
        bus_if.req_valid = 1'b1;
        bus_if.req_unit  = unit;
        bus_if.req_op    = op;
        bus_if.req_size  = size;
        bus_if.req_reg   = idx;
        bus_if.req_opa   = opa;
        bus_if.req_opb   = opb;
        step();
        bus_if.req_valid = 1'b0;
    endtask

    task automatic ack();
        bus_if.res_ack = 1'b1;
        step();
        bus_if.res_ack = 1'b0;
    endtask

    task automatic check_hold(input string tag, input logic [63:0] data,
                              input logic sign, input logic err);
        check({tag, ".valid"}, 64'(bus_if.res_valid), 64'd1);
        check({tag, ".data"},  bus_if.res_data, data);
        check({tag, ".sign"},  64'(bus_if.res_sign), 64'(sign));
        check({tag, ".err"},   64'(bus_if.res_err), 64'(err));
    endtask

    initial begin
        rst                = 1'b1;
        bus_if.req_valid   = 1'b0;
        bus_if.req_unit    = '0;
        bus_if.req_op      = '0;
        bus_if.req_size    = '0;
        bus_if.req_reg     = '0;
        bus_if.req_opa     = '0;
        bus_if.req_opb     = '0;
        bus_if.fpu_ready   = 1'b0;
        bus_if.fpu_result  = '0;
        bus_if.bm_result   = 64'h1234_5678_9ABC_DEF0;
        bus_if.calc_result = 64'hFFFF_0000_0000_8003;
        bus_if.log_result  = 64'h7000_0000_0000_0001;
        bus_if.res_ack     = 1'b0;
        steps(2);
        rst = 1'b0;

        // ---- reset state ----
        check("rst.req_ready", 64'(bus_if.req_ready), 64'd1);
        check("rst.res_valid", 64'(bus_if.res_valid), 64'd0);
        check("rst.res_data",  bus_if.res_data, 64'd0);
        check("rst.fpu_start", 64'(bus_if.fpu_start), 64'd0);
        check("rst.unit_opa",  bus_if.unit_opa, 64'd0);

        // ---- 1: int-calc, size 16 ----
        issue(3'b010, 3'd5, 2'b00, 2'd0, 64'h1_0000_8001, 64'd2);   // edge 1
        check("calc.req_ready", 64'(bus_if.req_ready), 64'd0);
        check("calc.unit_opa",  bus_if.unit_opa, 64'h8001);
        check("calc.unit_opb",  bus_if.unit_opb, 64'd2);
        check("calc.unit_op",   64'(bus_if.unit_op), 64'd5);
        check("calc.fpu_start", 64'(bus_if.fpu_start), 64'd0);
        check("calc.valid_e1",  64'(bus_if.res_valid), 64'd0);
        step();                                                     // edge 2
        check("calc.valid_e2",  64'(bus_if.res_valid), 64'd0);
        check("calc.opa_wait",  bus_if.unit_opa, 64'h8001);
        step();                                                     // edge 3
        check_hold("calc", 64'h8003, 1'b1, 1'b0);
        step();
        check_hold("calc_held", 64'h8003, 1'b1, 1'b0);
        check("calc.ready_hold", 64'(bus_if.req_ready), 64'd0);
        ack();
        check("calc.ack_valid", 64'(bus_if.res_valid), 64'd0);
        check("calc.ack_ready", 64'(bus_if.req_ready), 64'd1);
        check("calc.ack_sign",  64'(bus_if.res_sign), 64'd0);
        check("calc.ack_data",  bus_if.res_data, 64'h8003);

        // ---- bit-manip (32) and int-logic (64) result select ----
        issue(3'b001, 3'd1, 2'b01, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        check("bm.unit_opa", bus_if.unit_opa, 64'hFFFF_FFFF);
        step();
        step();
        check_hold("bm", 64'h9ABC_DEF0, 1'b1, 1'b0);
        ack();
        issue(3'b011, 3'd2, 2'b11, 2'd0, 64'd7, 64'd9);
        steps(2);
        check_hold("log", 64'h7000_0000_0000_0001, 1'b0, 1'b0);
        ack();

        // ---- 2: store then fetch ----
        issue(3'b101, 3'd0, 2'b10, 2'd2, 64'hDEAD_BEEF_0123_4567, 64'd0);
        step();
        check_hold("store", 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
        ack();
        issue(3'b100, 3'd0, 2'b01, 2'd2, 64'd0, 64'd0);
        step();
        check_hold("fetch2", 64'h0123_4567, 1'b0, 1'b0);
        ack();
        issue(3'b100, 3'd0, 2'b10, 2'd3, 64'd0, 64'd0);
        step();
        check_hold("fetch3", 64'd0, 1'b0, 1'b0);
        ack();

        // ---- 3: FPU ----
        bus_if.fpu_ready  = 1'b1;                 // stray pulse in IDLE
        bus_if.fpu_result = 64'h1234;
        step();
        bus_if.fpu_ready  = 1'b0;
        check("fpu.idle_valid", 64'(bus_if.res_valid), 64'd0);
        check("fpu.idle_ready", 64'(bus_if.req_ready), 64'd1);
        issue(3'b000, 3'd3, 2'b10, 2'd0, 64'd1, 64'd2);
        check("fpu.start_issue", 64'(bus_if.fpu_start), 64'd1);
        step();                                   // now WAIT cycle 1
        check("fpu.start_wait", 64'(bus_if.fpu_start), 64'd0);
        steps(4);                                 // now WAIT cycle 5
        check("fpu.valid_wait", 64'(bus_if.res_valid), 64'd0);
        bus_if.fpu_ready  = 1'b1;
        bus_if.fpu_result = 64'hC000_0000_0000_0000;
        step();
        bus_if.fpu_ready  = 1'b0;
        check_hold("fpu", 64'hC000_0000_0000_0000, 1'b1, 1'b0);
        ack();

        // ---- 4: FPU timeout and ready-on-last-cycle ----
        bus_if.fpu_result = 64'hFFFF_FFFF_FFFF_FFFF;
        issue(3'b000, 3'd1, 2'b10, 2'd0, 64'd0, 64'd0);
        step();                                   // WAIT cycle 1
        steps(7);                                 // WAIT cycle 8
        check("tmo.valid_c8", 64'(bus_if.res_valid), 64'd0);
        step();
        check_hold("tmo", 64'd0, 1'b0, 1'b1);
        ack();
        issue(3'b000, 3'd1, 2'b01, 2'd0, 64'd0, 64'd0);
        step();
        steps(7);                                 // WAIT cycle 8
        bus_if.fpu_ready  = 1'b1;
        bus_if.fpu_result = 64'hFFFF_FFFF_8000_0001;
        step();
        bus_if.fpu_ready  = 1'b0;
        check_hold("tmo_ready", 64'h8000_0001, 1'b1, 1'b0);
        ack();

        // ---- 5: illegal unit, req_valid held through HOLD ----
        issue(3'b110, 3'd0, 2'b10, 2'd0, 64'hFFFF, 64'hFFFF);
        bus_if.req_valid = 1'b1;                  // next request: store r1
        bus_if.req_unit  = 3'b101;
        bus_if.req_size  = 2'b00;
        bus_if.req_reg   = 2'd1;
        bus_if.req_opa   = 64'h55;
        step();
        check_hold("ill", 64'd0, 1'b0, 1'b1);
        steps(2);
        check("ill.ready_hold", 64'(bus_if.req_ready), 64'd0);
        check_hold("ill_held", 64'd0, 1'b0, 1'b1);
        ack();                                    // req_valid still high
        check("ill.ack_ready", 64'(bus_if.req_ready), 64'd1);
        check("ill.ack_valid", 64'(bus_if.res_valid), 64'd0);
        step();                                   // accepted here
        bus_if.req_valid = 1'b0;
        check("ill.reaccept", 64'(bus_if.req_ready), 64'd0);
        check("ill.new_opa",  bus_if.unit_opa, 64'h55);
        step();
        check_hold("ill_next", 64'h55, 1'b0, 1'b0);
        ack();
        step();
        check("ill.one_only", 64'(bus_if.req_ready), 64'd1);

        // ---- 6: reset during WAIT and during HOLD ----
        issue(3'b000, 3'd0, 2'b10, 2'd0, 64'd3, 64'd4);
        steps(2);                                 // in WAIT
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstw.ready", 64'(bus_if.req_ready), 64'd1);
        check("rstw.valid", 64'(bus_if.res_valid), 64'd0);
        check("rstw.opa",   bus_if.unit_opa, 64'd0);
        steps(10);
        check("rstw.no_res", 64'(bus_if.res_valid), 64'd0);
        issue(3'b101, 3'd0, 2'b10, 2'd1, 64'hAA, 64'd0);
        step();
        check_hold("pre_rsth", 64'hAA, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rsth.valid", 64'(bus_if.res_valid), 64'd0);
        check("rsth.data",  bus_if.res_data, 64'd0);
        check("rsth.ready", 64'(bus_if.req_ready), 64'd1);
        issue(3'b100, 3'd0, 2'b10, 2'd1, 64'd0, 64'd0);
        step();
        check_hold("rsth_r1", 64'd0, 1'b0, 1'b0);
        ack();
        issue(3'b100, 3'd0, 2'b10, 2'd2, 64'd0, 64'd0);
        step();
        check_hold("rsth_r2", 64'd0, 1'b0, 1'b0);
        ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
